// File: rtl/outbuf_fifo.sv
// rtl/outbuf_fifo.sv - registered output-side token FIFO with stop back-pressure
// Circular queue of DEPTH payloads; the valid bit is carried by the occupancy count.
module outbuf_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AFULL = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [W:0]                   core_data,
  output logic                         core_stop,
  output logic [W:0]                   out_data,
  input  logic                         out_stop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;

  // Explicit wrap so non-power-of-2 depths cycle through exactly DEPTH slots
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_enq   = core_data[W] && !w_full;
  assign w_deq   = !w_empty && !out_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_deq) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= core_data[W-1:0];
  end

  assign core_stop   = w_full;
  assign out_data    = {!w_empty, (w_empty ? {W{1'b0}} : r_mem[r_rd_ptr])};
  assign count       = r_count;
  assign almost_full = (r_count >= CW'(AFULL));

endmodule

// File: tb/tb_outbuf_fifo.sv
// tb/tb_outbuf_fifo.sv - directed self-checking bench for outbuf_fifo
// Instance a is DEPTH=4/AFULL=3; instance b is DEPTH=3 for pointer-wrap traffic.
module tb_outbuf_fifo;

  logic       clk;
  logic       rst_n;
  logic [8:0] a_core_data;
  logic       a_core_stop;
  logic [8:0] a_out_data;
  logic       a_out_stop;
  logic [2:0] a_count;
  logic       a_almost_full;
  logic [8:0] b_core_data;
  logic       b_core_stop;
  logic [8:0] b_out_data;
  logic       b_out_stop;
  logic [1:0] b_count;
  logic       b_almost_full;

  int n_checks;
  int n_fail;

  outbuf_fifo #(.W(8), .DEPTH(4), .AFULL(3)) u_a (
    .clk(clk), .rst_n(rst_n), .core_data(a_core_data), .core_stop(a_core_stop),
    .out_data(a_out_data), .out_stop(a_out_stop), .count(a_count),
    .almost_full(a_almost_full)
  );

  outbuf_fifo #(.W(8), .DEPTH(3), .AFULL(3)) u_b (
    .clk(clk), .rst_n(rst_n), .core_data(b_core_data), .core_stop(b_core_stop),
    .out_data(b_out_data), .out_stop(b_out_stop), .count(b_count),
    .almost_full(b_almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int sent;
    int rcv;
    int cyc;
    logic enq;
    logic deq;
    n_checks = 0;
    n_fail   = 0;

    // Reset held with a valid token on the input
    rst_n       = 1'b0;
    a_core_data = 9'h1AA;
    a_out_stop  = 1'b0;
    b_core_data = 9'h000;
    b_out_stop  = 1'b0;
    #2;
    chk("rst_stop_async", 32'(a_core_stop), 32'h0);
    chk("rst_out_async", 32'(a_out_data), 32'h000);
    tick();
    tick();
    chk("rst_stop", 32'(a_core_stop), 32'h0);
    chk("rst_out", 32'(a_out_data), 32'h000);
    chk("rst_count", 32'(a_count), 32'h0);
    chk("rst_afull", 32'(a_almost_full), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_count", 32'(a_count), 32'h1);
    chk("rel_out", 32'(a_out_data), 32'h1AA);
    a_core_data = 9'h000;
    tick();
    chk("rel_drain", 32'(a_count), 32'h0);
    chk("rel_drain_out", 32'(a_out_data), 32'h000);

    // Single token
    a_core_data = 9'h1A5;
    tick();
    a_core_data = 9'h0FF;
    chk("single_out", 32'(a_out_data), 32'h1A5);
    chk("single_cnt1", 32'(a_count), 32'h1);
    tick();
    chk("single_gone", 32'(a_out_data), 32'h000);
    chk("single_cnt0", 32'(a_count), 32'h0);
    tick();
    chk("single_invalid_ignored", 32'(a_count), 32'h0);

    // Fill to full, then drain in order
    a_out_stop = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a_core_data = 9'h100 + 9'(i);
      tick();
      chk("fill_count", 32'(a_count), (i < 4) ? 32'(i) : 32'h4);
      chk("fill_stop", 32'(a_core_stop), (i >= 4) ? 32'h1 : 32'h0);
      chk("fill_afull", 32'(a_almost_full), (i >= 3) ? 32'h1 : 32'h0);
      chk("fill_head", 32'(a_out_data), 32'h101);
    end
    a_out_stop = 1'b0;
    tick();
    chk("full_deq_only", 32'(a_count), 32'h3);
    chk("full_stop_drop", 32'(a_core_stop), 32'h0);
    chk("drain_102", 32'(a_out_data), 32'h102);
    tick();
    a_core_data = 9'h000;
    chk("both_count", 32'(a_count), 32'h3);
    chk("drain_103", 32'(a_out_data), 32'h103);
    tick();
    chk("drain_104", 32'(a_out_data), 32'h104);
    tick();
    chk("drain_105", 32'(a_out_data), 32'h105);
    chk("drain_cnt1", 32'(a_count), 32'h1);
    tick();
    chk("drain_empty", 32'(a_out_data), 32'h000);
    chk("drain_cnt0", 32'(a_count), 32'h0);

    // Simultaneous enqueue/dequeue with the queue full
    a_out_stop = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_core_data = 9'h120 + 9'(i);
      tick();
    end
    chk("sim_full", 32'(a_count), 32'h4);
    a_core_data = 9'h125;
    a_out_stop  = 1'b0;
    tick();
    chk("sim_edge1_cnt", 32'(a_count), 32'h3);
    chk("sim_edge1_out", 32'(a_out_data), 32'h122);
    tick();
    a_core_data = 9'h000;
    chk("sim_edge2_cnt", 32'(a_count), 32'h3);
    chk("sim_edge2_out", 32'(a_out_data), 32'h123);
    tick();
    chk("sim_124", 32'(a_out_data), 32'h124);
    tick();
    chk("sim_125", 32'(a_out_data), 32'h125);
    tick();
    chk("sim_empty", 32'(a_count), 32'h0);

    // DEPTH=3 wrap traffic with random downstream stop
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    while (rcv < 10 && cyc < 400) begin
      b_out_stop  = 1'($urandom_range(0, 1));
      b_core_data = (sent < 10) ? (9'h110 + 9'(sent)) : 9'h000;
      enq = b_core_data[8] && !b_core_stop;
      deq = b_out_data[8] && !b_out_stop;
      if (deq) begin
        chk("wrap_order", 32'(b_out_data), 32'h110 + 32'(rcv));
        rcv++;
      end
      if (enq) sent++;
      tick();
      chk("wrap_count", 32'(b_count), 32'(sent - rcv));
      chk("wrap_max", 32'(b_count <= 2'd3), 32'h1);
      cyc++;
    end
    chk("wrap_all_rcv", 32'(rcv), 32'd10);
    b_core_data = 9'h000;
    b_out_stop  = 1'b0;
    tick();
    chk("wrap_no_dup", 32'(b_out_data), 32'h000);

    // Mid-operation reset discards queued tokens
    a_out_stop = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_core_data = 9'h130 + 9'(i);
      tick();
    end
    a_core_data = 9'h000;
    chk("mid_pre_count", 32'(a_count), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(a_out_data), 32'h000);
    chk("mid_rst_count", 32'(a_count), 32'h0);
    chk("mid_rst_afull", 32'(a_almost_full), 32'h0);
    #2;
    rst_n      = 1'b1;
    a_out_stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_stale", 32'(a_out_data), 32'h000);
    end
    a_core_data = 9'h140;
    tick();
    a_core_data = 9'h000;
    chk("mid_fresh_out", 32'(a_out_data), 32'h140);
    chk("mid_fresh_cnt", 32'(a_count), 32'h1);
    tick();
    chk("mid_fresh_drain", 32'(a_out_data), 32'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
